// File: rtl/calc_page_sequencer_if.sv
// Bus between the calculator page sequencer and its neighbours (core, ROM banks, host).
// RES_VALID is a one-cycle pulse with no back-pressure: RES and RES_DIV are meaningful in the
// cycle RES_VALID is high and hold until the next result; the receiver must take them then.
interface calc_page_sequencer_if #(
    parameter int DATA_LEN  = 4,
    parameter int PC_LEN    = 7,
    parameter int INSTR_LEN = 8
);
    logic [PC_LEN-1:0]     PC;
    logic [DATA_LEN-1:0]   OPORT;
    logic [INSTR_LEN-1:0]  ROM_DATA;
    logic [DATA_LEN-1:0]   R2_IN;
    logic [DATA_LEN-1:0]   R3_IN;
    logic [DATA_LEN-1:0]   CMD_IN;
    logic [2:0]            ROM_SEL;
    logic [INSTR_LEN-1:0]  INSTR;
    logic [DATA_LEN-1:0]   IPORT;
    logic [2*DATA_LEN-1:0] RES;
    logic                  RES_VALID;
    logic                  RES_DIV;
    logic                  CMD_ERR;
    logic                  TO_ERR;

    modport master (
        output PC, OPORT, ROM_DATA, R2_IN, R3_IN, CMD_IN,
        input  ROM_SEL, INSTR, IPORT, RES, RES_VALID, RES_DIV, CMD_ERR, TO_ERR
    );

    modport slave (
        input  PC, OPORT, ROM_DATA, R2_IN, R3_IN, CMD_IN,
        output ROM_SEL, INSTR, IPORT, RES, RES_VALID, RES_DIV, CMD_ERR, TO_ERR
    );
endinterface

// File: rtl/calc_page_sequencer.sv
// Program-page sequencer for the 4-bit calculator core: decodes OPORT[1:0] signalling, picks
// the ROM page feeding INSTR, forces BRANCH 0 after each page change until the core is at PC 0,
// feeds operands/command on IPORT and captures the two-nibble result.
module calc_page_sequencer #(
    parameter int                   DATA_LEN  = 4,
    parameter int                   PC_LEN    = 7,
    parameter int                   INSTR_LEN = 8,
    parameter logic [INSTR_LEN-1:0] BR0_INSTR = 8'h80,
    parameter int                   TIMEOUT   = 4096
) (
    input  logic                CLK,
    input  logic                RSTN,
    calc_page_sequencer_if.slave bus,
    output logic [3:0]          dbg_state
);
    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] PG_LINK = 3'd0;
    localparam logic [2:0] PG_ADD  = 3'd1;
    localparam logic [2:0] PG_SUB  = 3'd2;
    localparam logic [2:0] PG_MUL  = 3'd3;
    localparam logic [2:0] PG_DIV  = 3'd4;

    typedef enum logic [3:0] {
        S_START, S_OP1, S_OP2, S_OP3, S_RUN, S_OTH1, S_OTH2, S_OTH3,
        S_RETW1, S_RETR1, S_RETW2, S_RETR2, S_RET, S_INR
    } state_t;

    state_t                state, state_eval, state_nxt;
    logic                  page_active;
    logic [2:0]            rom_sel;
    logic [DATA_LEN-1:0]   iport, lo_nib;
    logic [2*DATA_LEN-1:0] res;
    logic                  res_valid, res_div, cmd_err, to_err, is_div;
    logic [WD_W-1:0]       wdog;

    logic [1:0]            lo;
    logic                  page_go, set_div, ld_iport, cmd_bad, cap_lo, cap_res, wd_hit;
    logic [2:0]            page_nxt;
    logic [DATA_LEN-1:0]   iport_nxt;

    // An operand of zero would stall the core's loops, so it is delivered as one.
    function automatic logic [DATA_LEN-1:0] nz(input logic [DATA_LEN-1:0] v);
        return (v == '0) ? DATA_LEN'(1) : v;
    endfunction

    function automatic logic is_onehot(input logic [DATA_LEN-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    assign lo = bus.OPORT[1:0];

    // Next-state decode of the core signalling plus the side effects of each transition.
    always_comb begin
        state_eval = state;
        page_go    = 1'b0;
        page_nxt   = rom_sel;
        set_div    = 1'b0;
        ld_iport   = 1'b0;
        iport_nxt  = iport;
        cmd_bad    = 1'b0;
        cap_lo     = 1'b0;
        cap_res    = 1'b0;
        if (!page_active) begin
            case (state)
                S_START: if (lo == 2'd1) state_eval = S_OP1;
                         else if (lo == 2'd2) state_eval = S_OTH1;
                S_OP1:   if (lo == 2'd0) state_eval = S_OP2;
                         else if (lo == 2'd2) state_eval = S_OP3;
                S_OP2:   if (lo == 2'd1) begin
                             state_eval = S_RUN; page_go = 1'b1; page_nxt = PG_ADD;
                         end else if (lo == 2'd2) begin
                             state_eval = S_RUN; page_go = 1'b1; page_nxt = PG_DIV; set_div = 1'b1;
                         end
                S_OP3:   if (lo == 2'd1) begin
                             state_eval = S_RUN; page_go = 1'b1; page_nxt = PG_MUL;
                         end else if (lo == 2'd0) begin
                             state_eval = S_RUN; page_go = 1'b1; page_nxt = PG_SUB;
                         end
                S_RUN, S_RET, S_INR:
                         if (lo == 2'd3) state_eval = S_START;
                S_OTH1:  if (lo == 2'd0) state_eval = S_OTH2;
                         else if (lo == 2'd1) state_eval = S_OTH3;
                S_OTH2:  if (lo == 2'd2) state_eval = S_RETW1;
                         else if (lo == 2'd1) begin
                             state_eval = S_INR; ld_iport = 1'b1; iport_nxt = nz(bus.R2_IN);
                         end
                S_OTH3:  if (lo == 2'd0) begin
                             state_eval = S_INR; ld_iport = 1'b1; iport_nxt = nz(bus.R3_IN);
                         end else if (lo == 2'd2) begin
                             state_eval = S_INR; ld_iport = 1'b1; iport_nxt = bus.CMD_IN;
                             cmd_bad = !is_onehot(bus.CMD_IN);
                         end
                S_RETW1: state_eval = S_RETR1;
                S_RETR1: begin state_eval = S_RETW2; cap_lo = 1'b1; end
                S_RETW2: state_eval = S_RETR2;
                S_RETR2: begin
                    state_eval = S_RET; cap_res = 1'b1; page_go = 1'b1; page_nxt = PG_LINK;
                end
                default: state_eval = S_START;
            endcase
        end
        // A stalled sequence outside START that has used up its budget is aborted.
        wd_hit    = !page_active && (state != S_START) && (state_eval == state) && (wdog == WD_LAST);
        state_nxt = wd_hit ? S_START : state_eval;
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= S_START;
        else       state <= state_nxt;
    end

    // Page select, operand/result registers, pulses and watchdog counter.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            page_active <= 1'b0;
            rom_sel     <= PG_LINK;
            iport       <= '0;
            lo_nib      <= '0;
            res         <= '0;
            res_valid   <= 1'b0;
            res_div     <= 1'b0;
            cmd_err     <= 1'b0;
            to_err      <= 1'b0;
            is_div      <= 1'b0;
            wdog        <= '0;
        end else begin
            res_valid <= 1'b0;
            cmd_err   <= cmd_bad;
            to_err    <= wd_hit;
            if (wd_hit) begin
                rom_sel     <= PG_LINK;
                page_active <= 1'b1;
            end else if (page_go) begin
                rom_sel     <= page_nxt;
                page_active <= 1'b1;
            end else if (page_active && (bus.PC == '0)) begin
                page_active <= 1'b0;
            end
            if (wd_hit || cap_res) is_div <= 1'b0;
            else if (set_div)      is_div <= 1'b1;
            if (ld_iport) iport  <= iport_nxt;
            if (cap_lo)   lo_nib <= bus.OPORT;
            if (cap_res) begin
                res       <= {bus.OPORT, lo_nib};
                res_div   <= is_div;
                res_valid <= 1'b1;
            end
            if (page_active || (state == S_START) || (state_nxt != state)) wdog <= '0;
            else if (wdog != WD_LAST) wdog <= wdog + 1'b1;
        end
    end

    assign bus.INSTR     = page_active ? BR0_INSTR : bus.ROM_DATA;
    assign bus.ROM_SEL   = rom_sel;
    assign bus.IPORT     = iport;
    assign bus.RES       = res;
    assign bus.RES_VALID = res_valid;
    assign bus.RES_DIV   = res_div;
    assign bus.CMD_ERR   = cmd_err;
    assign bus.TO_ERR    = to_err;
    assign dbg_state     = state;
endmodule

// File: tb/tb_calc_page_sequencer.sv
// Bench for calc_page_sequencer: reset checks, a vector table, directed divide / readout /
// watchdog / mid-page reset sequences, and a randomized run against a word-level model.
module tb_calc_page_sequencer;
    localparam int         TO  = 4096;
    localparam logic [7:0] BR0 = 8'h80;

    logic       CLK  = 1'b0;
    logic       RSTN = 1'b0;
    logic [3:0] dbg_state;

    calc_page_sequencer_if bus ();
    calc_page_sequencer #(.TIMEOUT(TO)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus), .dbg_state(dbg_state));

    // Clock / reset
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] cur_rom;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [6:0] pc, input logic [3:0] r2,
                         input logic [3:0] r3, input logic [3:0] cmd);
        cur_rom      = 8'($urandom_range(0, 255));
        bus.OPORT    = op;
        bus.PC       = pc;
        bus.R2_IN    = r2;
        bus.R3_IN    = r3;
        bus.CMD_IN   = cmd;
        bus.ROM_DATA = cur_rom;
    endtask

    task automatic step(input logic [3:0] op, input logic [6:0] pc);
        drive(op, pc, 4'd7, 4'd9, 4'd1);
        tick();
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
    endtask

    // Reference model: the core speaks three-symbol command words; a completed word triggers
    // its action, after which the sequencer waits for symbol 3 (or runs a 4-cycle readout).
    typedef struct { int d0; int d1; int d2; int act; } word_t;
    localparam int A_RET = 5, A_R2 = 6, A_R3 = 7, A_CMD = 8;  // 1..4 = page to run
    word_t words[8];

    localparam int PH_DEC = 0, PH_READ = 1, PH_WAIT3 = 2;
    int         m_len, m_phase, m_rd, m_idle;
    int         m_dig[3];
    logic [2:0] m_sel;
    logic [3:0] m_ip, m_lonib;
    logic [7:0] m_res;
    bit         m_page, m_isdiv, m_rv, m_rdiv, m_ce, m_te;

    task automatic model_reset();
        m_len = 0; m_phase = PH_DEC; m_rd = 0; m_idle = 0;
        m_sel = 0; m_ip = 0; m_lonib = 0; m_res = 0;
        m_page = 0; m_isdiv = 0; m_rv = 0; m_rdiv = 0; m_ce = 0; m_te = 0;
    endtask

    // Word index for a full match, 8 for a valid partial prefix, -1 for no match.
    function automatic int lookup(input int a, input int b, input int c, input int n);
        for (int w = 0; w < 8; w++)
            if (words[w].d0 == a && (n < 2 || words[w].d1 == b) && (n < 3 || words[w].d2 == c))
                return (n == 3) ? w : 8;
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] op, input logic [6:0] pc, input logic [3:0] r2,
                              input logic [3:0] r3, input logic [3:0] cmd);
        int lo, r, act;
        bit prog, was_start;
        m_rv = 0; m_ce = 0; m_te = 0;
        if (m_page) begin
            m_idle = 0;
            if (pc == 0) m_page = 0;
            return;
        end
        lo = int'(op[1:0]);
        prog = 0;
        was_start = (m_phase == PH_DEC) && (m_len == 0);
        if (m_phase == PH_DEC) begin
            m_dig[m_len] = lo;
            r = lookup(m_dig[0], m_dig[1], m_dig[2], m_len + 1);
            if (r >= 0) begin
                prog = 1;
                m_len++;
                if (r < 8) begin
                    act = words[r].act;
                    m_len = 0;
                    m_phase = PH_WAIT3;
                    if (act <= 4) begin
                        m_sel = 3'(act); m_page = 1;
                        if (act == 4) m_isdiv = 1;
                    end else if (act == A_RET) begin
                        m_phase = PH_READ; m_rd = 0;
                    end else if (act == A_R2) m_ip = (r2 == 0) ? 4'd1 : r2;
                    else if (act == A_R3)     m_ip = (r3 == 0) ? 4'd1 : r3;
                    else begin
                        m_ip = cmd;
                        m_ce = ($countones(cmd) != 1);
                    end
                end
            end
        end else if (m_phase == PH_READ) begin
            prog = 1;
            if (m_rd == 1) m_lonib = op;
            if (m_rd == 3) begin
                m_res = {op, m_lonib}; m_rv = 1; m_rdiv = m_isdiv; m_isdiv = 0;
                m_sel = 0; m_page = 1; m_phase = PH_WAIT3;
            end
            m_rd++;
        end else if (lo == 3) begin
            prog = 1; m_phase = PH_DEC; m_len = 0;
        end
        if (prog || was_start) m_idle = 0;
        else if (m_idle == TO - 1) begin
            m_te = 1; m_len = 0; m_phase = PH_DEC; m_isdiv = 0; m_sel = 0; m_page = 1; m_idle = 0;
        end else m_idle++;
    endtask

    // Vector table
    typedef struct {
        logic [3:0] op; logic [6:0] pc; logic [3:0] r2; logic [3:0] r3; logic [3:0] cmd;
        logic [2:0] e_sel; logic e_page; logic [3:0] e_ip; logic e_ce;
    } vec_t;
    vec_t vecs[33];

    function automatic vec_t mk(input int op, input int pc, input int r2, input int r3, input int cmd,
                                input int sel, input int pg, input int ip, input int ce);
        vec_t v;
        v.op = 4'(op); v.pc = 7'(pc); v.r2 = 4'(r2); v.r3 = 4'(r3); v.cmd = 4'(cmd);
        v.e_sel = 3'(sel); v.e_page = 1'(pg); v.e_ip = 4'(ip); v.e_ce = 1'(ce);
        return v;
    endfunction

    initial begin
        logic [3:0] op, r2, r3, cmd;
        logic [6:0] pc;
        bit         seen;

        words[0] = '{1, 0, 1, 1};     words[1] = '{1, 0, 2, 4};
        words[2] = '{1, 2, 1, 3};     words[3] = '{1, 2, 0, 2};
        words[4] = '{2, 0, 2, A_RET}; words[5] = '{2, 0, 1, A_R2};
        words[6] = '{2, 1, 0, A_R3};  words[7] = '{2, 1, 2, A_CMD};

        vecs[0]  = mk(1, 5, 7, 9, 1, 0, 0, 0, 0);  vecs[1]  = mk(0, 6, 7, 9, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 5, 7, 9, 1, 1, 1, 0, 0);  vecs[3]  = mk(3, 6, 7, 9, 1, 1, 1, 0, 0);
        vecs[4]  = mk(3, 0, 7, 9, 1, 1, 0, 0, 0);  vecs[5]  = mk(3, 1, 7, 9, 1, 1, 0, 0, 0);
        vecs[6]  = mk(2, 2, 7, 9, 1, 1, 0, 0, 0);  vecs[7]  = mk(0, 2, 7, 9, 1, 1, 0, 0, 0);
        vecs[8]  = mk(1, 2, 0, 9, 1, 1, 0, 1, 0);  vecs[9]  = mk(3, 2, 7, 9, 1, 1, 0, 1, 0);
        vecs[10] = mk(2, 2, 7, 9, 1, 1, 0, 1, 0);  vecs[11] = mk(0, 2, 7, 9, 1, 1, 0, 1, 0);
        vecs[12] = mk(1, 2, 5, 9, 1, 1, 0, 5, 0);  vecs[13] = mk(3, 2, 7, 9, 1, 1, 0, 5, 0);
        vecs[14] = mk(2, 2, 7, 9, 1, 1, 0, 5, 0);  vecs[15] = mk(1, 2, 7, 9, 1, 1, 0, 5, 0);
        vecs[16] = mk(2, 2, 7, 9, 6, 1, 0, 6, 1);  vecs[17] = mk(3, 2, 7, 9, 1, 1, 0, 6, 0);
        vecs[18] = mk(2, 2, 7, 9, 1, 1, 0, 6, 0);  vecs[19] = mk(1, 2, 7, 9, 1, 1, 0, 6, 0);
        vecs[20] = mk(2, 2, 7, 9, 4, 1, 0, 4, 0);  vecs[21] = mk(3, 2, 7, 9, 1, 1, 0, 4, 0);
        vecs[22] = mk(2, 2, 7, 9, 1, 1, 0, 4, 0);  vecs[23] = mk(1, 2, 7, 9, 1, 1, 0, 4, 0);
        vecs[24] = mk(0, 2, 7, 0, 1, 1, 0, 1, 0);  vecs[25] = mk(3, 2, 7, 9, 1, 1, 0, 1, 0);
        vecs[26] = mk(0, 5, 7, 9, 1, 1, 0, 1, 0);  vecs[27] = mk(1, 5, 7, 9, 1, 1, 0, 1, 0);
        vecs[28] = mk(3, 5, 7, 9, 1, 1, 0, 1, 0);  vecs[29] = mk(2, 5, 7, 9, 1, 1, 0, 1, 0);
        vecs[30] = mk(0, 5, 7, 9, 1, 2, 1, 1, 0);  vecs[31] = mk(1, 0, 7, 9, 1, 2, 0, 1, 0);
        vecs[32] = mk(3, 5, 7, 9, 1, 2, 0, 1, 0);

        // Reset values
        drive(4'd0, 7'd0, 4'd0, 4'd0, 4'd0);
        bus.ROM_DATA = 8'h3C;
        cur_rom = 8'h3C;
        #1;
        check("rst_instr_in_reset", bus.INSTR, 8'h3C);
        do_reset();
        check("rst_rom_sel", bus.ROM_SEL, 0);
        check("rst_instr", bus.INSTR, 8'h3C);
        check("rst_iport", bus.IPORT, 0);
        check("rst_res", bus.RES, 0);
        check("rst_pulses", {bus.RES_VALID, bus.RES_DIV, bus.CMD_ERR, bus.TO_ERR}, 0);

        // Table-driven vectors: add page change, operand loads, command checks, subtract
        for (int i = 0; i < 33; i++) begin
            drive({2'($urandom_range(0, 3)), vecs[i].op[1:0]}, vecs[i].pc, vecs[i].r2, vecs[i].r3, vecs[i].cmd);
            tick();
            check($sformatf("tbl%0d_sel", i), bus.ROM_SEL, vecs[i].e_sel);
            check($sformatf("tbl%0d_instr", i), bus.INSTR, vecs[i].e_page ? BR0 : cur_rom);
            check($sformatf("tbl%0d_iport", i), bus.IPORT, vecs[i].e_ip);
            check($sformatf("tbl%0d_cmd_err", i), bus.CMD_ERR, vecs[i].e_ce);
            check($sformatf("tbl%0d_quiet", i), {bus.RES_VALID, bus.TO_ERR}, 0);
        end

        // Divide run, then readout of {3,1} -> 8'h13 flagged as divide
        step(1, 5); step(0, 5); step(2, 5);
        check("div_sel", bus.ROM_SEL, 4);
        check("div_instr_forced", bus.INSTR, BR0);
        step(3, 0);
        check("div_page_clear", bus.INSTR, cur_rom);
        step(3, 5);
        step(2, 5); step(0, 5); step(2, 5);
        step(4'hA, 5); step(4'h3, 5); step(4'hF, 5); step(4'h1, 5);
        check("rd_res", bus.RES, 8'h13);
        check("rd_valid", bus.RES_VALID, 1);
        check("rd_div", bus.RES_DIV, 1);
        check("rd_sel_link", bus.ROM_SEL, 0);
        check("rd_instr_forced", bus.INSTR, BR0);
        step(0, 5);
        check("rd_valid_pulse", bus.RES_VALID, 0);
        check("rd_res_hold", bus.RES, 8'h13);
        step(0, 0);
        check("rd_page_clear", bus.INSTR, cur_rom);
        step(3, 5);
        // Plain readout: divide flag must not linger
        step(2, 5); step(0, 5); step(2, 5);
        step(4'h0, 5); step(4'h5, 5); step(4'h0, 5); step(4'h9, 5);
        check("rd2_res", bus.RES, 8'h95);
        check("rd2_div", bus.RES_DIV, 0);
        check("rd2_valid", bus.RES_VALID, 1);
        step(0, 0); step(3, 5);

        // Watchdog: stall in OP1 for TO cycles after an add page
        step(1, 5); step(0, 5); step(1, 5);
        check("wd_pre_sel", bus.ROM_SEL, 1);
        step(3, 0); step(3, 5);
        step(1, 5);
        seen = 0;
        for (int i = 0; i < TO - 1; i++) begin
            step(3, 5);
            if (bus.TO_ERR) seen = 1;
        end
        check("wd_no_early", seen, 0);
        step(3, 5);
        check("wd_to_err", bus.TO_ERR, 1);
        check("wd_sel_link", bus.ROM_SEL, 0);
        check("wd_instr_forced", bus.INSTR, BR0);
        step(3, 5);
        check("wd_pulse_once", bus.TO_ERR, 0);
        step(1, 0);
        check("wd_page_clear", bus.INSTR, cur_rom);
        step(1, 5); step(0, 5); step(1, 5);
        check("wd_back_to_start", bus.ROM_SEL, 1);
        step(3, 0); step(3, 5);

        // Reset while a multiply page is being forced
        step(1, 5); step(2, 5); step(1, 5);
        check("mul_sel", bus.ROM_SEL, 3);
        check("mul_instr_forced", bus.INSTR, BR0);
        #2;
        RSTN = 1'b0;
        bus.ROM_DATA = 8'h5A;
        #1;
        check("arst_sel", bus.ROM_SEL, 0);
        check("arst_instr", bus.INSTR, 8'h5A);
        check("arst_iport", bus.IPORT, 0);
        check("arst_res", bus.RES, 0);

        // Randomized run against the model
        model_reset();
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            op  = 4'($urandom_range(0, 15));
            pc  = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            r2  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            r3  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            cmd = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            drive(op, pc, r2, r3, cmd);
            model_edge(op, pc, r2, r3, cmd);
            tick();
            check("rnd_sel", bus.ROM_SEL, m_sel);
            check("rnd_instr", bus.INSTR, m_page ? BR0 : cur_rom);
            check("rnd_iport", bus.IPORT, m_ip);
            check("rnd_res", bus.RES, m_res);
            check("rnd_res_valid", bus.RES_VALID, m_rv);
            check("rnd_res_div", bus.RES_DIV, m_rdiv);
            check("rnd_cmd_err", bus.CMD_ERR, m_ce);
            check("rnd_to_err", bus.TO_ERR, m_te);
        end

        // Report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
